// File: rtl/reflet_pwm_fader.sv
// reflet_pwm_fader: ramps the PWM core's duty_cycle toward a target in fixed
// steps, one step every periods_per_step PWM periods. Every duty change is
// registered on a PWM period boundary so the core never emits a cut pulse.
module reflet_pwm_fader #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] periods_per_step,
  input  logic [WIDTH-1:0] max_in,
  output logic [WIDTH-1:0] max,
  output logic [WIDTH-1:0] duty_cycle,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE = 1'b0, RAMP = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] duty_q, duty_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [WIDTH-1:0] step_q, step_d;
  logic [WIDTH-1:0] pps_q, pps_d;
  logic             done_q, done_d;
  logic             period_end;
  logic [WIDTH-1:0] next_duty;

  // A zero step or period count would stall the ramp, so it behaves as one.
  function automatic logic [WIDTH-1:0] at_least_one(input logic [WIDTH-1:0] v);
    return (v == '0) ? WIDTH'(1) : v;
  endfunction

  // Rising step saturating at the target; the extra sum bit rules out wrap.
  function automatic logic [WIDTH-1:0] step_up(input logic [WIDTH-1:0] cur,
                                               input logic [WIDTH-1:0] inc,
                                               input logic [WIDTH-1:0] lim);
    logic [WIDTH:0] sum;
    sum = {1'b0, cur} + {1'b0, inc};
    if (sum >= {1'b0, lim}) return lim;
    return sum[WIDTH-1:0];
  endfunction

  // Falling step saturating at the target; the remaining distance is compared
  // against the step before subtracting, so cur - dec never underflows.
  function automatic logic [WIDTH-1:0] step_down(input logic [WIDTH-1:0] cur,
                                                 input logic [WIDTH-1:0] dec,
                                                 input logic [WIDTH-1:0] lim);
    if ((cur - lim) <= dec) return lim;
    return cur - dec;
  endfunction

  // The core's counter wraps at max_in-1; a period of 0 or 1 ends every cycle.
  // Using >= lets a shrinking max_in end the current period immediately.
  assign period_end = (max_in <= WIDTH'(1)) || (cnt_q >= (max_in - WIDTH'(1)));

  // Candidate duty for an update; only committed on the update cycle.
  assign next_duty = (duty_q < tgt_q) ? step_up(duty_q, step_q, tgt_q)
                                      : step_down(duty_q, step_q, tgt_q);

  // Next-state logic: period tracking, start latching, update scheduling.
  always_comb begin
    state_d = state_q;
    cnt_d   = period_end ? '0 : (cnt_q + WIDTH'(1));
    pc_d    = pc_q;
    duty_d  = duty_q;
    tgt_d   = tgt_q;
    step_d  = step_q;
    pps_d   = pps_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          tgt_d  = target;
          step_d = at_least_one(step);
          pps_d  = at_least_one(periods_per_step);
          pc_d   = '0;
          if (target == duty_q) done_d  = 1'b1;
          else                  state_d = RAMP;
        end
      end
      RAMP: begin
        if (stop) begin
          state_d = IDLE;
        end else if (period_end) begin
          if (pc_q == (pps_q - WIDTH'(1))) begin
            pc_d   = '0;
            duty_d = next_duty;
            if (next_duty == tgt_q) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            pc_d = pc_q + WIDTH'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous active-low clear of everything.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pc_q    <= '0;
      duty_q  <= '0;
      tgt_q   <= '0;
      step_q  <= '0;
      pps_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      duty_q  <= duty_d;
      tgt_q   <= tgt_d;
      step_q  <= step_d;
      pps_q   <= pps_d;
      done_q  <= done_d;
    end
  end

  assign max        = max_in;
  assign duty_cycle = duty_q;
  assign busy       = (state_q == RAMP);
  assign done       = done_q;

endmodule

// File: tb/tb_reflet_pwm_fader.sv
// Bench for reflet_pwm_fader: directed ramps; expected duty/done/busy events
// are queued by the stimulus and matched by an independent monitor.
module tb_reflet_pwm_fader;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset, start, stop;
  logic [W-1:0] target, step, pps, max_in;
  logic [W-1:0] max_o, duty_cycle;
  logic         busy, done;

  int checks    = 0;
  int failures  = 0;
  int cyc       = 0;
  int ref_cycle = 0;
  int ev_id     = 0;

  typedef struct {
    int           id;
    logic [W-1:0] duty;
    logic         done;
    logic         busy;
    int           lo;
    int           hi;
  } exp_t;
  exp_t q[$];

  reflet_pwm_fader #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .target(target), .step(step), .periods_per_step(pps), .max_in(max_in),
    .max(max_o), .duty_cycle(duty_cycle), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // lo/hi: allowed clock edges since the start edge or the previous event.
  task automatic push(input logic [W-1:0] d, input logic dn, input logic b,
                      input int lo, input int hi);
    exp_t e;
    ev_id++;
    e.id = ev_id; e.duty = d; e.done = dn; e.busy = b; e.lo = lo; e.hi = hi;
    q.push_back(e);
  endtask

  task automatic start_ramp(input logic [W-1:0] t, input logic [W-1:0] s,
                            input logic [W-1:0] p);
    target = t; step = s; pps = p; start = 1'b1;
    tick();
    ref_cycle = cyc;
    start = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: %0d events pending after %0d cycles, expected 0",
               q.size(), budget);
      q.delete();
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    tick();
  endtask

  // Monitor: any duty change or done pulse is an event checked against the queue.
  initial begin : monitor
    logic [W-1:0] prev;
    exp_t         e;
    int           gap;
    prev = '0;
    forever begin
      @(negedge clk);
      if ((duty_cycle !== prev) || (done === 1'b1)) begin
        checks++;
        gap = cyc - ref_cycle;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_event: got duty=%0d done=%0d busy=%0d, expected no event",
                   duty_cycle, done, busy);
        end else begin
          e = q.pop_front();
          if (duty_cycle !== e.duty || done !== e.done || busy !== e.busy ||
              gap < e.lo || gap > e.hi) begin
            failures++;
            $display("FAIL event_%0d: got duty=%0d done=%0d busy=%0d gap=%0d, expected duty=%0d done=%0d busy=%0d gap=%0d..%0d",
                     e.id, duty_cycle, done, busy, gap, e.duty, e.done, e.busy, e.lo, e.hi);
          end
        end
        ref_cycle = cyc;
      end
      prev = duty_cycle;
    end
  end

  initial begin
    reset = 1'b0; start = 1'b0; stop = 1'b0;
    target = '0; step = '0; pps = '0; max_in = 8'd10;
    tick(3);
    chk("reset_duty", duty_cycle, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("max_passthru_10", max_o, 10);
    reset = 1'b1;
    tick(3);

    // Rising ramp 0 -> 9, step 3, one update per 10-cycle period.
    push(8'd3, 1'b0, 1'b1, 1, 10);
    push(8'd6, 1'b0, 1'b1, 10, 10);
    push(8'd9, 1'b1, 1'b0, 10, 10);
    start_ramp(8'd9, 8'd3, 8'd1);
    chk("busy_after_start", busy, 1);
    drain(40);
    tick(2);
    chk("busy_after_done", busy, 0);

    // Clamped rise 0 -> 10, then fall 10 -> 0 with step 4.
    push(8'd0, 1'b0, 1'b0, 0, 1000);
    do_reset();
    push(8'd3, 1'b0, 1'b1, 1, 10);
    push(8'd6, 1'b0, 1'b1, 10, 10);
    push(8'd9, 1'b0, 1'b1, 10, 10);
    push(8'd10, 1'b1, 1'b0, 10, 10);
    start_ramp(8'd10, 8'd3, 8'd1);
    drain(60);
    push(8'd6, 1'b0, 1'b1, 1, 10);
    push(8'd2, 1'b0, 1'b1, 10, 10);
    push(8'd0, 1'b1, 1'b0, 10, 10);
    start_ramp(8'd0, 8'd4, 8'd1);
    drain(50);

    // Reach 250 in one cycle-long period, then 250 -> 255 with step 10, pps 3.
    max_in = 8'd1;
    push(8'd250, 1'b1, 1'b0, 1, 1);
    start_ramp(8'd250, 8'd250, 8'd1);
    drain(10);
    max_in = 8'd4;
    #1;
    chk("max_passthru_4", max_o, 4);
    push(8'd255, 1'b1, 1'b0, 9, 12);
    start_ramp(8'd255, 8'd10, 8'd3);
    drain(30);
    tick(20);
    chk("overflow_hold_255", duty_cycle, 255);

    // Stop after the first update holds duty at 1 with no done.
    push(8'd0, 1'b0, 1'b0, 0, 1000);
    do_reset();
    max_in = 8'd10;
    push(8'd1, 1'b0, 1'b1, 1, 10);
    start_ramp(8'd9, 8'd1, 8'd1);
    drain(15);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("busy_after_stop", busy, 0);
    tick(25);
    chk("duty_held_after_stop", duty_cycle, 1);

    // Start while busy is ignored: the ramp keeps its step of 1 toward 9.
    push(8'd2, 1'b0, 1'b1, 1, 10);
    start_ramp(8'd9, 8'd1, 8'd1);
    drain(15);
    push(8'd3, 1'b0, 1'b1, 10, 10);
    target = 8'd0; step = 8'd5; pps = 8'd1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_start_ignored", busy, 1);
    drain(15);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick(15);
    chk("duty_after_second_stop", duty_cycle, 3);

    // Start with target equal to current duty: done next cycle, never busy.
    push(8'd3, 1'b1, 1'b0, 0, 0);
    start_ramp(8'd3, 8'd7, 8'd1);
    chk("equal_busy_k1", busy, 0);
    tick();
    chk("equal_busy_k2", busy, 0);
    drain(5);

    // Reset mid-ramp clears outputs and the ramp does not resume.
    push(8'd4, 1'b0, 1'b1, 1, 10);
    start_ramp(8'd200, 8'd1, 8'd1);
    drain(15);
    push(8'd0, 1'b0, 1'b0, 0, 1000);
    reset = 1'b0;
    tick();
    chk("midreset_duty", duty_cycle, 0);
    chk("midreset_busy", busy, 0);
    chk("midreset_done", done, 0);
    reset = 1'b1;
    tick(30);
    chk("after_reset_duty", duty_cycle, 0);
    chk("after_reset_busy", busy, 0);

    // max_in = 0 and 1: an update every cycle; step/pps of 0 act as 1.
    max_in = 8'd0;
    push(8'd1, 1'b0, 1'b1, 1, 1);
    push(8'd2, 1'b0, 1'b1, 1, 1);
    push(8'd3, 1'b1, 1'b0, 1, 1);
    start_ramp(8'd3, 8'd0, 8'd0);
    drain(10);
    max_in = 8'd1;
    push(8'd2, 1'b0, 1'b1, 1, 1);
    push(8'd1, 1'b0, 1'b1, 1, 1);
    push(8'd0, 1'b1, 1'b0, 1, 1);
    start_ramp(8'd0, 8'd1, 8'd1);
    drain(10);
    max_in = 8'd4;
    push(8'd1, 1'b0, 1'b1, 1, 4);
    push(8'd2, 1'b1, 1'b0, 4, 4);
    start_ramp(8'd2, 8'd0, 8'd0);
    drain(20);
    tick(5);

    chk("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
